// File: rtl/axi_read_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_burst_ctrl
// Purpose  : AXI4 read-channel slave. Turns AR/R bursts into single-word
//            read requests on the read port of a single-port SRAM macro,
//            reached through a shared arbiter (valid_o / grant_i). A
//            2-entry return buffer absorbs the 1-cycle SRAM read latency
//            and R-channel backpressure while sustaining one beat per cycle.
// Ports    : clk, rst_n      clock, synchronous active-low reset
//            AR*_i, ARREADY_o AXI4 read address channel (SIZE/LOCK/CACHE/
//                             PROT/REGION/QOS ignored, full-width beats)
//            R*_o, RREADY_i   AXI4 read data channel (RRESP always OKAY)
//            MEM_*            SRAM read port (CEN/WEN active-low)
//            valid_o, grant_i request / grant towards the memory arbiter
// Options  : AXI_READ_WRAP_EN  when defined, WRAP bursts of 2/4/8/16 beats
//                              wrap inside their aligned window; otherwise
//                              WRAP bursts are handled as INCR.
// Revision : 1.0  initial release
// ============================================================================
module axi_read_burst_ctrl #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_RDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_RDATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH     = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // read address channel
  input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
  input  logic [7:0]                    ARLEN_i,
  input  logic [2:0]                    ARSIZE_i,
  input  logic [1:0]                    ARBURST_i,
  input  logic                          ARLOCK_i,
  input  logic [3:0]                    ARCACHE_i,
  input  logic [2:0]                    ARPROT_i,
  input  logic [3:0]                    ARREGION_i,
  input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
  input  logic [3:0]                    ARQOS_i,
  input  logic                          ARVALID_i,
  output logic                          ARREADY_o,
  // read data channel
  output logic [AXI4_ID_WIDTH-1:0]      RID_o,
  output logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o,
  output logic [1:0]                    RRESP_o,
  output logic                          RLAST_o,
  output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
  output logic                          RVALID_o,
  input  logic                          RREADY_i,
  // SRAM read port
  output logic                          MEM_CEN_o,
  output logic                          MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
  output logic [AXI4_RDATA_WIDTH-1:0]   MEM_D_o,
  output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
  input  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i,
  // arbiter
  input  logic                          grant_i,
  output logic                          valid_o
);

  localparam int OFFSET_BIT = $clog2(AXI4_RDATA_WIDTH) - 3;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  // --------------------------------------------------------------------------
  // Burst context captured on AR acceptance
  // --------------------------------------------------------------------------
  logic [0:0]                  r_state;
  logic [AXI4_ID_WIDTH-1:0]    r_id;
  logic [AXI4_USER_WIDTH-1:0]  r_user;
  logic [7:0]                  r_len;
  logic                        r_fixed;
  logic [MEM_ADDR_WIDTH-1:0]   r_start;
  logic [7:0]                  r_count;

  // Tag of the request issued last cycle, paired with MEM_Q_i this cycle
  logic                        r_inflight;
  logic [AXI4_ID_WIDTH-1:0]    r_tag_id;
  logic [AXI4_USER_WIDTH-1:0]  r_tag_user;
  logic                        r_tag_last;

  // 2-entry return buffer
  logic [AXI4_RDATA_WIDTH-1:0] r_fifo_data [2];
  logic [AXI4_ID_WIDTH-1:0]    r_fifo_id   [2];
  logic [AXI4_USER_WIDTH-1:0]  r_fifo_user [2];
  logic                        r_fifo_last [2];
  logic                        r_wr_ptr;
  logic                        r_rd_ptr;
  logic [1:0]                  r_buf_count;

  logic                        w_ar_accept;
  logic                        w_pop;
  logic [2:0]                  w_occupancy;
  logic                        w_slot_free;
  logic                        w_issue;
  logic                        w_last_beat;
  logic [MEM_ADDR_WIDTH-1:0]   w_start_word;
  logic [MEM_ADDR_WIDTH-1:0]   w_incr_addr;
  logic [MEM_ADDR_WIDTH-1:0]   w_addr;
  logic                        w_unused_ar_fields;

  // Fields the controller deliberately ignores (full-width beats assumed)
  assign w_unused_ar_fields = ^{ARSIZE_i, ARLOCK_i, ARCACHE_i, ARPROT_i,
                                ARREGION_i, ARQOS_i, ARADDR_i};

  assign w_ar_accept  = (r_state == S_IDLE) && ARVALID_i;
  assign w_start_word = ARADDR_i[MEM_ADDR_WIDTH+OFFSET_BIT-1:OFFSET_BIT];
  assign w_pop        = (r_buf_count != 2'd0) && RREADY_i;

  // A buffer slot counts as free if it is empty now or is being drained in
  // this same cycle. Counting the concurrent pop is what allows one request
  // per cycle in steady state (one beat buffered + one in flight + one pop).
  assign w_occupancy  = {1'b0, r_buf_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_slot_free  = (w_occupancy < 3'd2);

  assign valid_o      = (r_state == S_BURST) && w_slot_free;
  assign w_issue      = valid_o && grant_i;
  assign w_last_beat  = (r_count == r_len);

  // INCR address wraps naturally at the top of the word-address space
  assign w_incr_addr  = r_start + MEM_ADDR_WIDTH'(r_count);

`ifdef AXI_READ_WRAP_EN
  logic                        r_wrap;
  logic                        w_wrap_len_ok;
  logic [MEM_ADDR_WIDTH-1:0]   w_mask;

  // Only power-of-two burst lengths of 2/4/8/16 beats may wrap
  assign w_wrap_len_ok = (ARLEN_i == 8'd1) || (ARLEN_i == 8'd3) ||
                         (ARLEN_i == 8'd7) || (ARLEN_i == 8'd15);
  assign w_mask        = MEM_ADDR_WIDTH'(r_len);

  always_ff @(posedge clk) begin
    if (w_ar_accept) begin
      r_wrap <= (ARBURST_i == 2'b10) && w_wrap_len_ok;
    end
  end

  always_comb begin
    w_addr = w_incr_addr;
    if (r_fixed) begin
      w_addr = r_start;
    end else if (r_wrap) begin
      w_addr = (r_start & ~w_mask) | (w_incr_addr & w_mask);
    end
  end
`else
  always_comb begin
    w_addr = w_incr_addr;
    if (r_fixed) begin
      w_addr = r_start;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= 8'd0;
      r_inflight  <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_buf_count <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ARVALID_i) begin
            r_state <= S_BURST;
            r_count <= 8'd0;
          end
        end
        S_BURST: begin
          if (w_issue) begin
            r_count <= r_count + 8'd1;
            // Leaving after the final issue lets the next AR be accepted
            // while this burst's last beats are still draining.
            if (w_last_beat) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      r_inflight <= w_issue;

      if (r_inflight) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_buf_count <= r_buf_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers (no reset needed; qualified by the control state)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_ar_accept) begin
      r_id    <= ARID_i;
      r_user  <= ARUSER_i;
      r_len   <= ARLEN_i;
      r_fixed <= (ARBURST_i == 2'b00);
      r_start <= w_start_word;
    end

    if (w_issue) begin
      r_tag_id   <= r_id;
      r_tag_user <= r_user;
      r_tag_last <= w_last_beat;
    end

    // SRAM data is valid the cycle after the accepted request
    if (r_inflight) begin
      r_fifo_data[r_wr_ptr] <= MEM_Q_i;
      r_fifo_id[r_wr_ptr]   <= r_tag_id;
      r_fifo_user[r_wr_ptr] <= r_tag_user;
      r_fifo_last[r_wr_ptr] <= r_tag_last;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ARREADY_o = (r_state == S_IDLE);

  assign RVALID_o  = (r_buf_count != 2'd0);
  assign RDATA_o   = r_fifo_data[r_rd_ptr];
  assign RID_o     = r_fifo_id[r_rd_ptr];
  assign RUSER_o   = r_fifo_user[r_rd_ptr];
  assign RLAST_o   = r_fifo_last[r_rd_ptr];
  assign RRESP_o   = 2'b00;

  assign MEM_CEN_o = ~w_issue;
  assign MEM_WEN_o = 1'b1;
  assign MEM_A_o   = w_addr;
  assign MEM_D_o   = '0;
  assign MEM_BE_o  = '1;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_burst_ctrl
// Purpose  : Self-checking bench for axi_read_burst_ctrl. A transaction-level
//            model predicts request addresses, beat order, handshake levels
//            and R-channel timing; directed tests pin the model with literal
//            expectations, then a randomized phase stresses it.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_read_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ARID_i;
  logic [31:0] ARADDR_i;
  logic [7:0]  ARLEN_i;
  logic [2:0]  ARSIZE_i;
  logic [1:0]  ARBURST_i;
  logic        ARLOCK_i;
  logic [3:0]  ARCACHE_i;
  logic [2:0]  ARPROT_i;
  logic [3:0]  ARREGION_i;
  logic [9:0]  ARUSER_i;
  logic [3:0]  ARQOS_i;
  logic        ARVALID_i;
  logic        ARREADY_o;
  logic [15:0] RID_o;
  logic [63:0] RDATA_o;
  logic [1:0]  RRESP_o;
  logic        RLAST_o;
  logic [9:0]  RUSER_o;
  logic        RVALID_o;
  logic        RREADY_i;
  logic        MEM_CEN_o;
  logic        MEM_WEN_o;
  logic [12:0] MEM_A_o;
  logic [63:0] MEM_D_o;
  logic [7:0]  MEM_BE_o;
  logic [63:0] MEM_Q_i;
  logic        grant_i;
  logic        valid_o;

  axi_read_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ARID_i(ARID_i), .ARADDR_i(ARADDR_i), .ARLEN_i(ARLEN_i), .ARSIZE_i(ARSIZE_i),
    .ARBURST_i(ARBURST_i), .ARLOCK_i(ARLOCK_i), .ARCACHE_i(ARCACHE_i),
    .ARPROT_i(ARPROT_i), .ARREGION_i(ARREGION_i), .ARUSER_i(ARUSER_i),
    .ARQOS_i(ARQOS_i), .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
    .RID_o(RID_o), .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RLAST_o(RLAST_o),
    .RUSER_o(RUSER_o), .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
    .MEM_CEN_o(MEM_CEN_o), .MEM_WEN_o(MEM_WEN_o), .MEM_A_o(MEM_A_o),
    .MEM_D_o(MEM_D_o), .MEM_BE_o(MEM_BE_o), .MEM_Q_i(MEM_Q_i),
    .grant_i(grant_i), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  // Content of every SRAM word is a fixed function of its address
  function automatic logic [63:0] mem_word(input logic [12:0] a);
    return 64'hDEAD_0000_0000_0000 ^ ({51'd0, a} * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  // SRAM model: data one cycle after an enabled read, garbage otherwise
  always @(posedge clk) begin
    if (!MEM_CEN_o) MEM_Q_i <= mem_word(MEM_A_o);
    else            MEM_Q_i <= {$urandom, $urandom};
  end

  typedef struct {
    logic [15:0] id;
    logic [9:0]  user;
    logic        last;
    logic [12:0] addr;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          mode   = 0;   // 0 fixed, 1 random RREADY/grant, 2 grant toggles
  logic [12:0] exp_req[$];   // addresses still to be requested
  beat_t       exp_beat[$];  // beats still to be returned
  int          out_cyc[$];   // issue cycle of each request not yet returned
  logic        ar_hs;
  int          ar_cyc;
  // logs for directed literal checks
  logic [12:0] req_addr_log[$];
  int          req_cyc_log[$];
  int          beat_cyc_log[$];
  logic [15:0] beat_id_log[$];
  logic        beat_last_log[$];
  // one-cycle history for stability checks
  logic        hold_r = 1'b0, hold_g = 1'b0;
  logic [15:0] prev_rid;
  logic [63:0] prev_rdata;
  logic        prev_rlast;
  logic [9:0]  prev_ruser;
  logic [12:0] prev_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle=%0d", name, cyc);
  endtask

  // Expand one accepted AR into its ordered address list and beat list
  task automatic model_ar();
    int n, s, a;
    beat_t b;
    n = int'(ARLEN_i) + 1;
    s = int'(ARADDR_i[15:3]);
    for (int i = 0; i < n; i++) begin
      if (ARBURST_i == 2'b00) begin
        a = s;
`ifdef AXI_READ_WRAP_EN
      end else if (ARBURST_i == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
        a = (s / n) * n + ((s % n) + i) % n;
`endif
      end else begin
        a = (s + i) % 8192;
      end
      exp_req.push_back(13'(a));
      b.id = ARID_i; b.user = ARUSER_i; b.last = (i == n - 1); b.addr = 13'(a);
      exp_beat.push_back(b);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  task automatic monitor();
    logic  pop;
    beat_t b;
    if (!rst_n) begin
      exp_req.delete(); exp_beat.delete(); out_cyc.delete();
      hold_r = 1'b0; hold_g = 1'b0;
      return;
    end
    pop = RVALID_o && RREADY_i;
    chk("arready", ARREADY_o, exp_req.size() == 0);
    chk("valid_o", valid_o, (exp_req.size() != 0) && ((out_cyc.size() - int'(pop)) < 2));
    chk("mem_cen", MEM_CEN_o, !(valid_o && grant_i));
    chk("rvalid", RVALID_o, (out_cyc.size() != 0) && (out_cyc[0] <= cyc - 2));
    if (hold_g) begin
      chk("hold_valid", valid_o, 1'b1);
      chk("hold_addr", MEM_A_o, prev_a);
    end
    if (hold_r) begin
      chk("hold_rid", RID_o, prev_rid);
      chk("hold_rdata", RDATA_o, prev_rdata);
      chk("hold_rlast", RLAST_o, prev_rlast);
      chk("hold_ruser", RUSER_o, prev_ruser);
    end
    if (ARVALID_i && ARREADY_o) begin
      ar_hs  = 1'b1;
      ar_cyc = cyc;
      model_ar();
    end
    if (!MEM_CEN_o) begin
      if (exp_req.size() == 0) fail("spurious_request");
      else chk("mem_addr", MEM_A_o, exp_req.pop_front());
      req_addr_log.push_back(MEM_A_o);
      req_cyc_log.push_back(cyc);
      out_cyc.push_back(cyc);
    end
    if (pop) begin
      if (exp_beat.size() == 0) fail("spurious_beat");
      else begin
        b = exp_beat.pop_front();
        chk("rid", RID_o, b.id);
        chk("ruser", RUSER_o, b.user);
        chk("rlast", RLAST_o, b.last);
        chk("rresp", RRESP_o, 2'b00);
        chk("rdata", RDATA_o, mem_word(b.addr));
      end
      if (out_cyc.size() != 0) void'(out_cyc.pop_front());
      beat_cyc_log.push_back(cyc);
      beat_id_log.push_back(RID_o);
      beat_last_log.push_back(RLAST_o);
    end
    hold_r = RVALID_o && !RREADY_i;
    prev_rid = RID_o; prev_rdata = RDATA_o; prev_rlast = RLAST_o; prev_ruser = RUSER_o;
    hold_g = valid_o && !grant_i;
    prev_a = MEM_A_o;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (mode == 1) begin
      RREADY_i = ($urandom % 4) != 0;
      grant_i  = ($urandom % 3) != 0;
    end else if (mode == 2) begin
      grant_i = ~grant_i;
    end
  endtask

  task automatic send_ar(input logic [15:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst,
                         input logic [9:0] user);
    ARID_i = id; ARADDR_i = addr; ARLEN_i = len; ARBURST_i = burst; ARUSER_i = user;
    ARSIZE_i = 3'($urandom); ARLOCK_i = 1'($urandom); ARCACHE_i = 4'($urandom);
    ARPROT_i = 3'($urandom); ARREGION_i = 4'($urandom); ARQOS_i = 4'($urandom);
    ARVALID_i = 1'b1;
    ar_hs = 1'b0;
    for (int n = 0; n < 300 && !ar_hs; n++) tick();
    if (!ar_hs) fail("ar_timeout");
    ARVALID_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_req.size() != 0 || exp_beat.size() != 0 || out_cyc.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) fail("drain_timeout");
    tick();
  endtask

  task automatic clear_logs();
    req_addr_log.delete(); req_cyc_log.delete();
    beat_cyc_log.delete(); beat_id_log.delete(); beat_last_log.delete();
  endtask

  initial begin
    int          ar2_cyc;
    int          wrap_exp[4];
    logic [31:0] addr;
    logic [7:0]  len;

`ifdef AXI_READ_WRAP_EN
    wrap_exp = '{6, 7, 4, 5};
`else
    wrap_exp = '{6, 7, 8, 9};
`endif
    rst_n = 1'b0; ARVALID_i = 1'b0; ARID_i = '0; ARADDR_i = '0; ARLEN_i = '0;
    ARSIZE_i = '0; ARBURST_i = '0; ARLOCK_i = '0; ARCACHE_i = '0; ARPROT_i = '0;
    ARREGION_i = '0; ARUSER_i = '0; ARQOS_i = '0; RREADY_i = 1'b1; grant_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_arready", ARREADY_o, 1'b1);
    chk("reset_rvalid", RVALID_o, 1'b0);
    chk("reset_valid_o", valid_o, 1'b0);
    chk("reset_cen", MEM_CEN_o, 1'b1);
    chk("mem_wen", MEM_WEN_o, 1'b1);
    chk("mem_be", MEM_BE_o, 8'hFF);
    chk("mem_d", MEM_D_o, 64'd0);

    // Single beat at byte 0x40 -> word 8
    clear_logs();
    send_ar(16'd5, 32'h40, 8'd0, 2'b01, 10'h15);
    wait_drain();
    if (req_addr_log.size() != 1 || beat_id_log.size() != 1) fail("single_counts");
    else begin
      chk("single_addr", req_addr_log[0], 13'd8);
      chk("single_rid", beat_id_log[0], 16'd5);
      chk("single_rlast", beat_last_log[0], 1'b1);
      chk("single_latency", beat_cyc_log[0], ar_cyc + 3);
    end

    // INCR 8 beats from word 0x10, full throughput
    clear_logs();
    send_ar(16'h0A, 32'h80, 8'd7, 2'b01, 10'h2A);
    wait_drain();
    if (req_addr_log.size() != 8 || beat_cyc_log.size() != 8) fail("incr_counts");
    else begin
      for (int i = 0; i < 8; i++) begin
        chk("incr_addr", req_addr_log[i], 13'(16 + i));
        chk("incr_req_cycle", req_cyc_log[i], req_cyc_log[0] + i);
        chk("incr_beat_cycle", beat_cyc_log[i], beat_cyc_log[0] + i);
        chk("incr_rlast", beat_last_log[i], i == 7);
      end
    end

    // Backpressure: only two requests while RREADY is low
    clear_logs();
    RREADY_i = 1'b0;
    send_ar(16'h0B, 32'h100, 8'd3, 2'b01, 10'h3);
    repeat (5) tick();
    chk("bp_requests", req_addr_log.size(), 2);
    chk("bp_valid_o", valid_o, 1'b0);
    RREADY_i = 1'b1;
    wait_drain();
    chk("bp_beats", beat_id_log.size(), 4);
    if (req_addr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("bp_addr", req_addr_log[i], 13'(32 + i));
    else fail("bp_req_total");

    // Grant toggling
    clear_logs();
    mode = 2;
    send_ar(16'h0C, 32'h180, 8'd3, 2'b01, 10'h7);
    wait_drain();
    mode = 0; grant_i = 1'b1;
    if (req_addr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("grant_addr", req_addr_log[i], 13'(48 + i));
    else fail("grant_req_total");

    // Back-to-back ARs
    clear_logs();
    send_ar(16'd1, 32'h200, 8'd1, 2'b01, 10'h1);
    send_ar(16'd2, 32'h300, 8'd0, 2'b01, 10'h2);
    ar2_cyc = ar_cyc;
    wait_drain();
    if (beat_id_log.size() != 3) fail("b2b_beats");
    else begin
      chk("b2b_rid0", beat_id_log[0], 16'd1);
      chk("b2b_rid1", beat_id_log[1], 16'd1);
      chk("b2b_rid2", beat_id_log[2], 16'd2);
      chk("b2b_last0", beat_last_log[0], 1'b0);
      chk("b2b_last1", beat_last_log[1], 1'b1);
      chk("b2b_last2", beat_last_log[2], 1'b1);
      chk("b2b_overlap", ar2_cyc < beat_cyc_log[1], 1'b1);
    end

    // WRAP 4 beats from word 6
    clear_logs();
    send_ar(16'h0D, 32'h30, 8'd3, 2'b10, 10'h9);
    wait_drain();
    if (req_addr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("wrap_addr", req_addr_log[i], 13'(wrap_exp[i]));
    else fail("wrap_req_total");

    // Reset in the middle of a burst
    send_ar(16'h0E, 32'h400, 8'd15, 2'b01, 10'h4);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_rvalid", RVALID_o, 1'b0);
    chk("midrst_valid_o", valid_o, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("midrst_arready", ARREADY_o, 1'b1);
    chk("midrst_rvalid2", RVALID_o, 1'b0);

    // Randomized traffic
    mode = 1;
    for (int k = 0; k < 60; k++) begin
      addr = $urandom;
      if ($urandom % 4 == 0) addr[15:3] = 13'h1FF8 + 13'($urandom % 8);
      case ($urandom % 6)
        0:       len = 8'd0;
        1:       len = 8'd31;
        default: len = 8'($urandom % 16);
      endcase
      send_ar(16'($urandom), addr, len, 2'($urandom), 10'($urandom));
      repeat ($urandom % 3) tick();
    end
    wait_drain();
    mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
